// File: rtl/jk_ubus_master_engine.sv
// UBUS initiator: takes one command, then runs arbitration, the address
// phase and 1..8 byte beats, and returns the response on a valid/ready port.
module jk_ubus_master_engine #(
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic        cmd_write,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        req,
    input  logic        gnt,
    output logic [15:0] addr,
    output logic [1:0]  size,
    output logic        read,
    output logic        write,
    output logic        bip,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    input  logic        wait_state,
    input  logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_ADDR, S_DATA, S_RESP
    } state_t;

    state_t      r_state, w_state;
    logic [2:0]  r_beat, w_beat;
    logic [15:0] r_wcnt, w_wcnt;
    logic [15:0] r_addr_c, w_addr_c;
    logic [1:0]  r_size_c, w_size_c;
    logic        r_write_c, w_write_c;
    logic [63:0] r_wdata_c, w_wdata_c;

    logic        r_cmd_ready, w_cmd_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic [63:0] r_rsp_rdata, w_rsp_rdata;
    logic        r_rsp_error, w_rsp_error;
    logic        r_rsp_timeout, w_rsp_timeout;
    logic        r_req, w_req;
    logic [15:0] r_addr, w_addr;
    logic [1:0]  r_size, w_size;
    logic        r_read, w_read;
    logic        r_write, w_write;
    logic        r_bip, w_bip;
    logic [7:0]  r_data_out, w_data_out;
    logic        r_data_oe, w_data_oe;

    logic [2:0]  w_last;
    logic [2:0]  w_beat_inc;
    logic [15:0] w_wcnt_inc;
    logic        w_to_hit;
    logic        w_done;

    // 1 << size wraps to 0 for size 3, so the subtraction still yields 7
    assign w_last     = (3'd1 << r_size_c) - 3'd1;
    assign w_beat_inc = r_beat + 3'd1;
    assign w_wcnt_inc = r_wcnt + 16'd1;
    assign w_to_hit   = (WAIT_TIMEOUT != 0) &&
                        (w_wcnt_inc == 16'(WAIT_TIMEOUT));

    always_comb begin
        w_state       = r_state;
        w_beat        = r_beat;
        w_wcnt        = r_wcnt;
        w_addr_c      = r_addr_c;
        w_size_c      = r_size_c;
        w_write_c     = r_write_c;
        w_wdata_c     = r_wdata_c;
        w_cmd_ready   = r_cmd_ready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_error   = r_rsp_error;
        w_rsp_timeout = r_rsp_timeout;
        w_req         = r_req;
        w_addr        = r_addr;
        w_size        = r_size;
        w_read        = r_read;
        w_write       = r_write;
        w_bip         = r_bip;
        w_data_out    = r_data_out;
        w_data_oe     = r_data_oe;
        w_done        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_addr_c    = cmd_addr;
                    w_size_c    = cmd_size;
                    w_write_c   = cmd_write;
                    w_wdata_c   = cmd_wdata;
                    w_cmd_ready = 1'b0;
                    w_req       = 1'b1;
                    w_state     = S_ARB;
                end
            end
            S_ARB: begin
                if (gnt) begin
                    w_req   = 1'b0;
                    w_addr  = r_addr_c;
                    w_size  = r_size_c;
                    w_read  = ~r_write_c;
                    w_write = r_write_c;
                    w_state = S_ADDR;
                end
            end
            S_ADDR: begin
                w_addr     = '0;
                w_size     = '0;
                w_read     = 1'b0;
                w_write    = 1'b0;
                w_beat     = '0;
                w_wcnt     = '0;
                w_bip      = (w_last != 3'd0);
                w_data_oe  = r_write_c;
                w_data_out = r_write_c ? r_wdata_c[7:0] : 8'h00;
                w_state    = S_DATA;
            end
            S_DATA: begin
                if (error) begin
                    w_rsp_error = 1'b1;
                    w_done      = 1'b1;
                end else if (wait_state) begin
                    w_wcnt = w_wcnt_inc;
                    if (w_to_hit) begin
                        w_rsp_error   = 1'b1;
                        w_rsp_timeout = 1'b1;
                        w_done        = 1'b1;
                    end
                end else begin
                    if (!r_write_c)
                        w_rsp_rdata[{r_beat, 3'b000} +: 8] = data_in;
                    w_wcnt = '0;
                    if (r_beat == w_last) begin
                        w_done = 1'b1;
                    end else begin
                        w_beat     = w_beat_inc;
                        w_bip      = (w_beat_inc != w_last);
                        w_data_out = r_write_c ?
                            8'(r_wdata_c >> {w_beat_inc, 3'b000}) : 8'h00;
                    end
                end
                if (w_done) begin
                    w_rsp_valid = 1'b1;
                    w_bip       = 1'b0;
                    w_data_oe   = 1'b0;
                    w_data_out  = 8'h00;
                    w_wcnt      = '0;
                    w_state     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid   = 1'b0;
                    w_rsp_rdata   = '0;
                    w_rsp_error   = 1'b0;
                    w_rsp_timeout = 1'b0;
                    w_cmd_ready   = 1'b1;
                    w_state       = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_beat        <= '0;
            r_wcnt        <= '0;
            r_addr_c      <= '0;
            r_size_c      <= '0;
            r_write_c     <= 1'b0;
            r_wdata_c     <= '0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_size        <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_bip         <= 1'b0;
            r_data_out    <= '0;
            r_data_oe     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_beat        <= w_beat;
            r_wcnt        <= w_wcnt;
            r_addr_c      <= w_addr_c;
            r_size_c      <= w_size_c;
            r_write_c     <= w_write_c;
            r_wdata_c     <= w_wdata_c;
            r_cmd_ready   <= w_cmd_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_error   <= w_rsp_error;
            r_rsp_timeout <= w_rsp_timeout;
            r_req         <= w_req;
            r_addr        <= w_addr;
            r_size        <= w_size;
            r_read        <= w_read;
            r_write       <= w_write;
            r_bip         <= w_bip;
            r_data_out    <= w_data_out;
            r_data_oe     <= w_data_oe;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;
    assign req         = r_req;
    assign addr        = r_addr;
    assign size        = r_size;
    assign read        = r_read;
    assign write       = r_write;
    assign bip         = r_bip;
    assign data_out    = r_data_out;
    assign data_oe     = r_data_oe;

endmodule

// File: tb/tb_jk_ubus_master_engine.sv
// Directed bench for jk_ubus_master_engine: a table of transfers replayed
// against a scripted slave, plus a hand-written mid-transfer reset.
module tb_jk_ubus_master_engine;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_addr = '0;
    logic [1:0]  cmd_size = '0;
    logic        cmd_write = 1'b0;
    logic [63:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        req;
    logic        gnt = 1'b0;
    logic [15:0] addr;
    logic [1:0]  size;
    logic        read;
    logic        write;
    logic        bip;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in = '0;
    logic        wait_state = 1'b0;
    logic        error = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    jk_ubus_master_engine #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .req(req), .gnt(gnt), .addr(addr), .size(size),
        .read(read), .write(write), .bip(bip),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .wait_state(wait_state), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [15:0] a;
        logic [63:0] wdata;
        logic [63:0] slave;
        int          gnt_delay;
        int          wait_beat;
        int          wait_n;
        int          err_beat;
        int          rsp_hold;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v, input int id);
        int          last;
        logic [63:0] tmp;
        logic [63:0] hold;
        bit          ab;
        string       p;
        p    = $sformatf("v%0d", id);
        last = (1 << v.sz) - 1;
        ab   = 1'b0;
        chk({p, " idle_ready"}, 64'(cmd_ready), 64'd1);
        chk({p, " idle_rsp"}, 64'(rsp_valid), 64'd0);
        cmd_valid = 1'b1;
        cmd_addr  = v.a;
        cmd_size  = v.sz;
        cmd_write = v.wr;
        cmd_wdata = v.wdata;
        gnt       = (v.gnt_delay == 0);
        step();
        chk({p, " acc_ready"}, 64'(cmd_ready), 64'd0);
        chk({p, " req_c1"}, 64'(req), 64'd1);
        // a busy engine must not pick up a changed command
        cmd_addr  = ~v.a;
        cmd_wdata = ~v.wdata;
        cmd_write = ~v.wr;
        for (int i = 1; i <= v.gnt_delay; i++) begin
            step();
            chk({p, " req_hold"}, 64'(req), 64'd1);
            chk({p, " arb_ready"}, 64'(cmd_ready), 64'd0);
            if (i == v.gnt_delay) gnt = 1'b1;
        end
        cmd_valid = 1'b0;
        step();
        gnt = 1'b0;
        chk({p, " addr_req"}, 64'(req), 64'd0);
        chk({p, " addr"}, 64'(addr), 64'(v.a));
        chk({p, " size"}, 64'(size), 64'(v.sz));
        chk({p, " read"}, 64'(read), 64'(!v.wr));
        chk({p, " write"}, 64'(write), 64'(v.wr));
        chk({p, " addr_oe"}, 64'(data_oe), 64'd0);
        step();
        for (int b = 0; b <= last && !ab; b++) begin
            for (int c = 0; c < 64; c++) begin
                tmp = v.wdata >> (8 * b);
                chk({p, " oe"}, 64'(data_oe), 64'(v.wr));
                chk({p, " dout"}, 64'(data_out),
                    v.wr ? 64'(tmp[7:0]) : 64'd0);
                chk({p, " bip"}, 64'(bip), 64'(b != last));
                chk({p, " strobes"}, {62'd0, read, write}, 64'd0);
                if (b == v.err_beat) begin
                    error = 1'b1;
                    step();
                    error = 1'b0;
                    ab = 1'b1;
                    break;
                end
                if (b == v.wait_beat && c < v.wait_n) begin
                    wait_state = 1'b1;
                    step();
                    wait_state = 1'b0;
                    if (c + 1 == TO) begin
                        ab = 1'b1;
                        break;
                    end
                    continue;
                end
                tmp = v.slave >> (8 * b);
                data_in = tmp[7:0];
                step();
                data_in = 8'h00;
                break;
            end
        end
        chk({p, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({p, " rsp_error"}, 64'(rsp_error), 64'(v.exp_err));
        chk({p, " rsp_timeout"}, 64'(rsp_timeout), 64'(v.exp_to));
        chk({p, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({p, " resp_oe"}, 64'(data_oe), 64'd0);
        chk({p, " resp_bip"}, 64'(bip), 64'd0);
        chk({p, " resp_dout"}, 64'(data_out), 64'd0);
        chk({p, " resp_ready"}, 64'(cmd_ready), 64'd0);
        hold = rsp_rdata;
        for (int h = 0; h < v.rsp_hold; h++) begin
            step();
            chk({p, " hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({p, " hold_rdata"}, rsp_rdata, v.exp_rdata);
            chk({p, " hold_err"}, 64'(rsp_error), 64'(v.exp_err));
            chk({p, " hold_ready"}, 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({p, " done_valid"}, 64'(rsp_valid), 64'd0);
        chk({p, " done_ready"}, 64'(cmd_ready), 64'd1);
        chk({p, " done_rdata"}, rsp_rdata, 64'd0);
        chk({p, " done_err"}, {62'd0, rsp_error, rsp_timeout}, 64'd0);
    endtask

    initial begin
        //         wr  sz     addr      wdata                  slave
        //         gd wb wn eb hold exp_rdata               err to
        vecs[0] = '{1'b1, 2'b10, 16'h1234, 64'h44332211, 64'h0,
                    0, -1, 0, -1, 0, 64'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'b01, 16'h0010, 64'h0, 64'hCDAB,
                    0, 0, 2, -1, 0, 64'h000000000000CDAB, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 2'b11, 16'h0200, 64'h8877665544332211, 64'h0,
                    0, -1, 0, 1, 0, 64'h0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 2'b00, 16'h0300, 64'h0, 64'h5A,
                    0, 0, 20, -1, 0, 64'h0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 2'b00, 16'hABCD, 64'h0, 64'h7E,
                    5, -1, 0, -1, 3, 64'h7E, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 2'b11, 16'hFFFF, 64'h0, 64'h0123456789ABCDEF,
                    0, 5, 15, -1, 0, 64'h0123456789ABCDEF, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'b10, 16'h0040, 64'h0, 64'hDDCCBBAA,
                    0, -1, 0, 2, 1, 64'h000000000000BBAA, 1'b1, 1'b0};

        #12;
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_outs", {data_oe, bip, read, write, req, rsp_valid,
                         rsp_error, rsp_timeout, 56'd0}, 64'd0);
        chk("rst_bus", {30'd0, addr, size, data_out, 8'd0}, 64'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run(vecs[i], i);

        // reset during beat 2 of an 8-byte write
        cmd_valid = 1'b1;
        cmd_addr  = 16'h0BEE;
        cmd_size  = 2'b11;
        cmd_write = 1'b1;
        cmd_wdata = 64'h8877665544332211;
        gnt       = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        gnt = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_dout", 64'(data_out), 64'h33);
        chk("pre_rst_oe", 64'(data_oe), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_outs", {data_oe, bip, read, write, req, rsp_valid,
                             rsp_error, rsp_timeout, 56'd0}, 64'd0);
        chk("mid_rst_dout", 64'(data_out), 64'd0);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
            chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        end
        run(vecs[0], 7);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
